// File: rtl/video_pkg.sv
// Shared types for the video stream generator: pattern encodings, FSM
// states and the DE_PERIOD legality rule.
package video_pkg;

    typedef enum logic [1:0] {
        PAT_XY    = 2'd0,  // low half (x+1), high half y
        PAT_X     = 2'd1,  // x
        PAT_Y     = 2'd2,  // y
        PAT_CONST = 2'd3   // constant value
    } pattern_e;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_GAP    = 3'd1,
        ST_PIX    = 3'd2,
        ST_HBLANK = 3'd3,
        ST_VBLANK = 3'd4
    } state_e;

    // DE_PERIOD of 1 would mean "zero empty cycles" twice over; only 0 or >= 2 are meaningful.
    function automatic bit de_period_legal(input int de_period);
        return (de_period == 0) || (de_period >= 2);
    endfunction

endpackage

// File: rtl/video_stream_gen_if.sv
// Internal bus between the timing FSM (master) and the pattern generator
// (slave): pixel coordinates and pattern selection out, pixel value back.
interface video_stream_gen_if
    import video_pkg::*;
#(
    parameter int PIXEL_WIDTH = 8,
    parameter int CNT_WIDTH   = 16
);

    logic [CNT_WIDTH-1:0]   x;
    logic [CNT_WIDTH-1:0]   y;
    pattern_e               pattern;
    logic [PIXEL_WIDTH-1:0] const_value;
    logic [PIXEL_WIDTH-1:0] pixel;

    modport master (output x, y, pattern, const_value, input  pixel);
    modport slave  (input  x, y, pattern, const_value, output pixel);

endinterface

// File: rtl/video_pattern_gen.sv
// Combinational pixel pattern generator. Coordinates wrap silently: only
// the low bits that fit the selected field are kept.
module video_pattern_gen
    import video_pkg::*;
#(
    parameter int PIXEL_WIDTH = 8,
    parameter int CNT_WIDTH   = 16
) (
    video_stream_gen_if.slave pat
);

    localparam int HALF = PIXEL_WIDTH / 2;

    logic [CNT_WIDTH-1:0] x_inc;

    assign x_inc = pat.x + CNT_WIDTH'(1);

    // Select the pixel value for the current coordinates.
    always_comb begin
        // NOTE: every output of a combinational block gets a default first so
        // no path leaves it unassigned, which would otherwise infer a latch.
        pat.pixel = '0;
        case (pat.pattern)
            PAT_XY: begin
                pat.pixel[HALF-1:0]      = HALF'(x_inc);
                pat.pixel[2*HALF-1:HALF] = HALF'(pat.y);
            end
            PAT_X:     pat.pixel = PIXEL_WIDTH'(pat.x);
            PAT_Y:     pat.pixel = PIXEL_WIDTH'(pat.y);
            PAT_CONST: pat.pixel = pat.const_value;
            default:   pat.pixel = '0;
        endcase
    end

endmodule

// File: rtl/video_stream_gen.sv
// Video test-stream generator: frame/line timing FSM with pixel, line and
// frame counters. Every output is registered; outputs are decoded from the
// next state so they line up with the state they describe.
module video_stream_gen
    import video_pkg::*;
#(
    parameter int PIXEL_WIDTH = 8,
    parameter int DE_PERIOD   = 0,
    parameter int CNT_WIDTH   = 16
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   start_i,
    input  logic                   stop_i,
    input  logic [CNT_WIDTH-1:0]   width_i,
    input  logic [CNT_WIDTH-1:0]   height_i,
    input  logic [CNT_WIDTH-1:0]   hblank_i,
    input  logic [CNT_WIDTH-1:0]   vblank_i,
    input  logic [CNT_WIDTH-1:0]   frames_i,
    input  logic [1:0]             pattern_i,
    input  logic [PIXEL_WIDTH-1:0] const_i,
    output logic [PIXEL_WIDTH-1:0] do_o,
    output logic                   de_o,
    output logic                   hs_o,
    output logic                   vs_o,
    output logic                   busy_o,
    output logic                   frame_done_o
);

    if (!de_period_legal(DE_PERIOD)) begin : g_de_period_illegal
        $error("video_stream_gen: DE_PERIOD must be 0 or >= 2");
    end

    localparam logic [CNT_WIDTH-1:0] ONE = CNT_WIDTH'(1);
    // GAP holds for DE_PERIOD-1 cycles, counted down to zero.
    localparam logic [CNT_WIDTH-1:0] GAP_LOAD =
        (DE_PERIOD >= 2) ? CNT_WIDTH'(DE_PERIOD - 2) : '0;
    localparam state_e FIRST_STATE = (DE_PERIOD >= 2) ? ST_GAP : ST_PIX;

    state_e state, state_next;

    logic [CNT_WIDTH-1:0] x, x_next;
    logic [CNT_WIDTH-1:0] y, y_next;
    logic [CNT_WIDTH-1:0] cnt, cnt_next;
    logic [CNT_WIDTH-1:0] frame_cnt, frame_cnt_next;
    logic                 stop, stop_next;

    logic [CNT_WIDTH-1:0]   width_q, height_q, hblank_q, vblank_q, frames_q;
    pattern_e               pattern_q;
    logic [PIXEL_WIDTH-1:0] const_q;

    logic                   launch;
    logic                   last_line;
    logic                   frame_over;
    logic                   finish_run;
    logic                   frame_done_next;
    logic [PIXEL_WIDTH-1:0] do_next;
    logic                   de_next, hs_next, vs_next, busy_next;

    video_stream_gen_if #(
        .PIXEL_WIDTH (PIXEL_WIDTH),
        .CNT_WIDTH   (CNT_WIDTH)
    ) pat_bus ();

    video_pattern_gen #(
        .PIXEL_WIDTH (PIXEL_WIDTH),
        .CNT_WIDTH   (CNT_WIDTH)
    ) u_pattern (
        .pat (pat_bus)
    );

    // On the launch cycle the configuration is not latched yet, so the
    // pattern selection is taken straight from the inputs.
    assign launch    = (state == ST_IDLE) && start_i && (width_i != '0) && (height_i != '0);
    assign last_line = (y == height_q - ONE);

    assign pat_bus.x           = x_next;
    assign pat_bus.y           = y_next;
    assign pat_bus.pattern     = launch ? pattern_e'(pattern_i) : pattern_q;
    assign pat_bus.const_value = launch ? const_i : const_q;

    // Latch the run configuration when a valid start is accepted.
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so every
        // register samples the values from before this clock edge.
        if (!rst_n) begin
            width_q   <= '0;
            height_q  <= '0;
            hblank_q  <= '0;
            vblank_q  <= '0;
            frames_q  <= '0;
            pattern_q <= PAT_XY;
            const_q   <= '0;
        end else if (launch) begin
            width_q   <= width_i;
            height_q  <= height_i;
            hblank_q  <= hblank_i;
            vblank_q  <= vblank_i;
            frames_q  <= frames_i;
            pattern_q <= pattern_e'(pattern_i);
            const_q   <= const_i;
        end
    end

    // Next-state and counter logic of the timing FSM.
    always_comb begin
        state_next      = state;
        x_next          = x;
        y_next          = y;
        cnt_next        = cnt;
        frame_cnt_next  = frame_cnt;
        frame_done_next = 1'b0;
        frame_over      = 1'b0;
        stop_next       = (state != ST_IDLE) && (stop || stop_i);
        finish_run      = stop_next || ((frames_q != '0) && (frame_cnt == frames_q));

        case (state)
            ST_IDLE: begin
                if (launch) begin
                    x_next         = '0;
                    y_next         = '0;
                    frame_cnt_next = '0;
                    cnt_next       = GAP_LOAD;
                    state_next     = FIRST_STATE;
                end
            end
            ST_GAP: begin
                if (cnt == '0) state_next = ST_PIX;
                else           cnt_next   = cnt - ONE;
            end
            ST_PIX: begin
                if (x < width_q - ONE) begin
                    x_next     = x + ONE;
                    cnt_next   = GAP_LOAD;
                    state_next = FIRST_STATE;
                end else begin
                    state_next = ST_HBLANK;
                    cnt_next   = (hblank_q == '0) ? '0 : hblank_q - ONE;
                    if (last_line) begin
                        frame_done_next = 1'b1;
                        frame_cnt_next  = frame_cnt + ONE;
                    end
                end
            end
            ST_HBLANK: begin
                if (cnt != '0) begin
                    cnt_next = cnt - ONE;
                end else if (!last_line) begin
                    x_next     = '0;
                    y_next     = y + ONE;
                    cnt_next   = GAP_LOAD;
                    state_next = FIRST_STATE;
                end else if (vblank_q != '0) begin
                    state_next = ST_VBLANK;
                    cnt_next   = vblank_q - ONE;
                end else begin
                    frame_over = 1'b1;
                end
            end
            ST_VBLANK: begin
                if (cnt != '0) cnt_next   = cnt - ONE;
                else           frame_over = 1'b1;
            end
            default: state_next = ST_IDLE;
        endcase

        if (frame_over) begin
            if (finish_run) begin
                state_next = ST_IDLE;
                stop_next  = 1'b0;
            end else begin
                x_next     = '0;
                y_next     = '0;
                cnt_next   = GAP_LOAD;
                state_next = FIRST_STATE;
            end
        end
    end

    // Output decode from the state being entered, so outputs register in step with it.
    always_comb begin
        do_next   = '0;
        de_next   = 1'b0;
        hs_next   = 1'b0;
        vs_next   = 1'b0;
        busy_next = (state_next != ST_IDLE);
        case (state_next)
            ST_IDLE: hs_next = 1'b1;
            ST_GAP:  vs_next = 1'b1;
            ST_PIX: begin
                de_next = 1'b1;
                vs_next = 1'b1;
                do_next = pat_bus.pixel;
            end
            ST_HBLANK: begin
                hs_next = 1'b1;
                vs_next = (y_next != height_q - ONE);
            end
            ST_VBLANK: hs_next = 1'b1;
            default:   hs_next = 1'b1;
        endcase
    end

    // State, counter and output registers; reset aborts any frame in flight.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state        <= ST_IDLE;
            x            <= '0;
            y            <= '0;
            cnt          <= '0;
            frame_cnt    <= '0;
            stop         <= 1'b0;
            do_o         <= '0;
            de_o         <= 1'b0;
            hs_o         <= 1'b1;
            vs_o         <= 1'b0;
            busy_o       <= 1'b0;
            frame_done_o <= 1'b0;
        end else begin
            state        <= state_next;
            x            <= x_next;
            y            <= y_next;
            cnt          <= cnt_next;
            frame_cnt    <= frame_cnt_next;
            stop         <= stop_next;
            do_o         <= do_next;
            de_o         <= de_next;
            hs_o         <= hs_next;
            vs_o         <= vs_next;
            busy_o       <= busy_next;
            frame_done_o <= frame_done_next;
        end
    end

endmodule

// File: tb/tb_video_stream_gen.sv
// Scoreboard bench for video_stream_gen: stimulus pushes expected pixels and
// per-cycle control traces into queues; monitors pop and compare.
module tb_video_stream_gen;

    typedef struct packed {
        logic de;
        logic hs;
        logic vs;
        logic busy;
        logic fd;
    } ctl_t;

    localparam ctl_t C_IDLE = 5'b01000;
    localparam ctl_t C_GAP  = 5'b00110;
    localparam ctl_t C_PIX  = 5'b10110;
    localparam ctl_t C_HB   = 5'b01110;  // hblank of a non-last line
    localparam ctl_t C_HBF  = 5'b01011;  // first hblank cycle of the last line
    localparam ctl_t C_HBL  = 5'b01010;  // later hblank cycles of the last line
    localparam ctl_t C_VB   = 5'b01010;

    logic        clk = 1'b0;
    logic        rst_n, start_i, start4, stop_i;
    logic [15:0] width_i, height_i, hblank_i, vblank_i, frames_i;
    logic [1:0]  pattern_i;
    logic [7:0]  const_i;

    logic [7:0]  do0, do4;
    logic        de0, hs0, vs0, busy0, fd0;
    logic        de4, hs4, vs4, busy4, fd4;

    logic [7:0]  pix0_q[$], pix4_q[$];
    ctl_t        trc0_q[$], trc4_q[$];

    int tests = 0;
    int fails = 0;
    int fd0_count = 0;
    int fd4_count = 0;
    int fd_base;

    always #5 clk = ~clk;

    video_stream_gen #(.PIXEL_WIDTH(8), .DE_PERIOD(0), .CNT_WIDTH(16)) dut0 (
        .clk(clk), .rst_n(rst_n), .start_i(start_i), .stop_i(stop_i),
        .width_i(width_i), .height_i(height_i), .hblank_i(hblank_i), .vblank_i(vblank_i),
        .frames_i(frames_i), .pattern_i(pattern_i), .const_i(const_i),
        .do_o(do0), .de_o(de0), .hs_o(hs0), .vs_o(vs0), .busy_o(busy0), .frame_done_o(fd0)
    );

    video_stream_gen #(.PIXEL_WIDTH(8), .DE_PERIOD(4), .CNT_WIDTH(16)) dut4 (
        .clk(clk), .rst_n(rst_n), .start_i(start4), .stop_i(stop_i),
        .width_i(width_i), .height_i(height_i), .hblank_i(hblank_i), .vblank_i(vblank_i),
        .frames_i(frames_i), .pattern_i(pattern_i), .const_i(const_i),
        .do_o(do4), .de_o(de4), .hs_o(hs4), .vs_o(vs4), .busy_o(busy4), .frame_done_o(fd4)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Monitor for the DE_PERIOD=0 instance.
    always @(negedge clk) begin
        if (trc0_q.size() != 0) check("trace0", {de0, hs0, vs0, busy0, fd0}, trc0_q.pop_front());
        if (de0) begin
            if (pix0_q.size() == 0) check("unexpected_de0", de0, 1'b0);
            else                    check("pixel0", do0, pix0_q.pop_front());
        end
        if (fd0) fd0_count++;
    end

    // Monitor for the DE_PERIOD=4 instance.
    always @(negedge clk) begin
        if (trc4_q.size() != 0) check("trace4", {de4, hs4, vs4, busy4, fd4}, trc4_q.pop_front());
        if (de4) begin
            if (pix4_q.size() == 0) check("unexpected_de4", de4, 1'b0);
            else                    check("pixel4", do4, pix4_q.pop_front());
        end
        if (fd4) fd4_count++;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic cfg(input int w, input int h, input int hb, input int vb,
                       input int fr, input int pat, input int cv);
        width_i   = 16'(w);
        height_i  = 16'(h);
        hblank_i  = 16'(hb);
        vblank_i  = 16'(vb);
        frames_i  = 16'(fr);
        pattern_i = 2'(pat);
        const_i   = 8'(cv);
    endtask

    task automatic seg0(input int n, input ctl_t c);
        for (int i = 0; i < n; i++) trc0_q.push_back(c);
    endtask

    task automatic seg4(input int n, input ctl_t c);
        for (int i = 0; i < n; i++) trc4_q.push_back(c);
    endtask

    task automatic pulse_start0();
        start_i = 1'b1;
        tick();
        start_i = 1'b0;
    endtask

    task automatic wait_idle0();
        int n = 0;
        while (busy0 && n < 300) begin
            tick();
            n++;
        end
        check("idle0_timeout", busy0, 1'b0);
        repeat (2) tick();
    endtask

    initial begin
        rst_n = 1'b0; start_i = 1'b0; start4 = 1'b0; stop_i = 1'b0;
        cfg(0, 0, 0, 0, 0, 0, 0);
        repeat (3) tick();

        // Reset state.
        check("rst_do", do0, 8'h00);
        check("rst_de", de0, 1'b0);
        check("rst_hs", hs0, 1'b1);
        check("rst_vs", vs0, 1'b0);
        check("rst_busy", busy0, 1'b0);
        check("rst_fd", fd0, 1'b0);
        check("rst_hs4", hs4, 1'b1);
        rst_n = 1'b1;
        repeat (2) tick();

        // 4x2 pattern 0, hblank 3, vblank 2, one frame; config churn mid-frame.
        fd_base = fd0_count;
        cfg(4, 2, 3, 2, 1, 0, 0);
        foreach (pix0_q[i]) ;
        pix0_q.push_back(8'h01); pix0_q.push_back(8'h02); pix0_q.push_back(8'h03); pix0_q.push_back(8'h04);
        pix0_q.push_back(8'h11); pix0_q.push_back(8'h12); pix0_q.push_back(8'h13); pix0_q.push_back(8'h14);
        seg0(1, C_IDLE); seg0(4, C_PIX); seg0(3, C_HB); seg0(4, C_PIX);
        seg0(1, C_HBF); seg0(2, C_HBL); seg0(2, C_VB); seg0(1, C_IDLE);
        pulse_start0();
        cfg(7, 9, 0, 0, 0, 3, 8'h5A);
        wait_idle0();
        check("fd_4x2", fd0_count - fd_base, 1);

        // Constant pattern, 2x1, hblank 0: single hblank cycle with vs falling.
        fd_base = fd0_count;
        cfg(2, 1, 0, 0, 1, 3, 8'hA5);
        pix0_q.push_back(8'hA5); pix0_q.push_back(8'hA5);
        seg0(1, C_IDLE); seg0(2, C_PIX); seg0(1, C_HBF); seg0(1, C_IDLE);
        pulse_start0();
        wait_idle0();
        check("fd_const", fd0_count - fd_base, 1);

        // Pattern 0 with 17 pixels: the x+1 nibble wraps past 15.
        cfg(17, 1, 0, 0, 1, 0, 0);
        for (int i = 1; i <= 17; i++) pix0_q.push_back(8'(i % 16));
        pulse_start0();
        wait_idle0();

        // Pattern 1 (x), 3x2.
        cfg(3, 2, 1, 0, 1, 1, 0);
        for (int r = 0; r < 2; r++) for (int i = 0; i < 3; i++) pix0_q.push_back(8'(i));
        pulse_start0();
        wait_idle0();

        // Pattern 2 (y), 2x3, two frames with vblank 1.
        fd_base = fd0_count;
        cfg(2, 3, 0, 1, 2, 2, 0);
        for (int f = 0; f < 2; f++) for (int r = 0; r < 3; r++) begin
            pix0_q.push_back(8'(r)); pix0_q.push_back(8'(r));
        end
        pulse_start0();
        wait_idle0();
        check("fd_two_frames", fd0_count - fd_base, 2);

        // Zero-geometry starts are ignored.
        fd_base = fd0_count;
        cfg(0, 2, 0, 0, 1, 0, 0);
        pulse_start0();
        repeat (3) tick();
        check("w0_busy", busy0, 1'b0);
        check("w0_hs", hs0, 1'b1);
        cfg(3, 0, 0, 0, 1, 0, 0);
        pulse_start0();
        repeat (3) tick();
        check("h0_busy", busy0, 1'b0);

        // start_i while busy is ignored.
        cfg(2, 1, 2, 0, 1, 1, 0);
        pix0_q.push_back(8'h00); pix0_q.push_back(8'h01);
        pulse_start0();
        cfg(5, 3, 0, 0, 0, 2, 0);
        pulse_start0();
        wait_idle0();
        check("fd_busy_start", fd0_count - fd_base, 1);

        // DE_PERIOD=4 instance: three empty cycles before each pixel.
        fd_base = fd4_count;
        cfg(3, 1, 1, 0, 1, 1, 0);
        pix4_q.push_back(8'h00); pix4_q.push_back(8'h01); pix4_q.push_back(8'h02);
        seg4(1, C_IDLE);
        for (int i = 0; i < 3; i++) begin
            seg4(3, C_GAP); seg4(1, C_PIX);
        end
        seg4(1, C_HBF); seg4(1, C_IDLE);
        start4 = 1'b1;
        tick();
        start4 = 1'b0;
        repeat (20) tick();
        check("busy4_end", busy4, 1'b0);
        check("fd_de4", fd4_count - fd_base, 1);

        // Continuous run, stop mid frame 2: frame 2 completes, then idle.
        fd_base = fd0_count;
        cfg(2, 2, 1, 1, 0, 2, 0);
        for (int f = 0; f < 2; f++) begin
            pix0_q.push_back(8'h00); pix0_q.push_back(8'h00);
            pix0_q.push_back(8'h01); pix0_q.push_back(8'h01);
        end
        pulse_start0();
        begin
            int n = 0;
            while (!fd0 && n < 100) begin
                tick();
                n++;
            end
        end
        check("fd_wait", fd0, 1'b1);
        repeat (3) tick();
        stop_i = 1'b1;
        tick();
        stop_i = 1'b0;
        wait_idle0();
        check("fd_stop", fd0_count - fd_base, 2);

        // Reset during a pixel of line 1 aborts the frame.
        fd_base = fd0_count;
        cfg(4, 2, 1, 0, 0, 0, 0);
        pix0_q.push_back(8'h01); pix0_q.push_back(8'h02); pix0_q.push_back(8'h03); pix0_q.push_back(8'h04);
        pix0_q.push_back(8'h11); pix0_q.push_back(8'h12);
        pulse_start0();
        repeat (6) tick();
        check("pre_reset_de", de0, 1'b1);
        rst_n = 1'b0;
        tick();
        check("mid_rst_hs", hs0, 1'b1);
        check("mid_rst_vs", vs0, 1'b0);
        check("mid_rst_de", de0, 1'b0);
        check("mid_rst_busy", busy0, 1'b0);
        check("mid_rst_do", do0, 8'h00);
        rst_n = 1'b1;
        repeat (3) tick();
        check("post_rst_idle", busy0, 1'b0);
        check("fd_aborted", fd0_count - fd_base, 0);
        cfg(2, 1, 0, 0, 1, 0, 0);
        pix0_q.push_back(8'h01); pix0_q.push_back(8'h02);
        pulse_start0();
        wait_idle0();
        check("fd_restart", fd0_count - fd_base, 1);

        check("pix0_left", pix0_q.size(), 0);
        check("pix4_left", pix4_q.size(), 0);
        check("trc0_left", trc0_q.size(), 0);
        check("trc4_left", trc4_q.size(), 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
